// File: rtl/gate_sweep_checker_if.sv
// Stimulus/response bundle between gate_sweep_checker (master) and its environment (slave).
// The N_IN given to this interface must match the N_IN of the checker it connects to.
interface gate_sweep_checker_if #(
  parameter int N_IN = 2
);
  logic            start;
  logic [N_IN-1:0] gate_in;
  logic            gate_out;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic [N_IN-1:0] first_fail_vec;
  logic            first_fail_valid;

  modport master (
    input  start, gate_out,
    output gate_in, busy, done, pass, err_count, first_fail_vec, first_fail_valid
  );

  modport slave (
    output start, gate_out,
    input  gate_in, busy, done, pass, err_count, first_fail_vec, first_fail_valid
  );
endinterface

// File: rtl/gate_sweep_checker.sv
// Exhaustive truth-table sweeper/checker for a combinational gate under test.
// Optional macro GATE_SWEEP_STOP_ON_FAIL_EN: end the sweep at the first mismatching vector.
module gate_sweep_checker #(
  parameter int N_IN    = 2,
  parameter int SETTLE  = 2,
  parameter int GATE_FN = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  gate_sweep_checker_if.master sweep
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

  if (N_IN < 1 || N_IN > 8) begin : g_bad_n_in
    $error("gate_sweep_checker: N_IN must be in 1..8");
  end
  if (SETTLE < 1) begin : g_bad_settle
    $error("gate_sweep_checker: SETTLE must be >= 1");
  end
  if (GATE_FN < 0 || GATE_FN > 5) begin : g_bad_gate_fn
    $error("gate_sweep_checker: GATE_FN must be in 0..5");
  end

  typedef enum logic [1:0] {
    ST_IDLE, ST_SETTLE, ST_CHECK, ST_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_IN-1:0] gate_in_q, gate_in_d;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN-1:0] ff_vec_q, ff_vec_d;
  logic            ff_valid_q, ff_valid_d;
  logic            pass_q, pass_d;

  function automatic logic ref_fn(input logic [N_IN-1:0] v);
    case (GATE_FN)
      0:       return &v;
      1:       return |v;
      2:       return ^v;
      3:       return ~&v;
      4:       return ~|v;
      default: return ~^v;
    endcase
  endfunction

  logic mismatch, last_vec, stop_hit;
  assign mismatch = (sweep.gate_out != ref_fn(gate_in_q));
  assign last_vec = &gate_in_q;
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
  assign stop_hit = mismatch;
`else
  assign stop_hit = 1'b0;
`endif

  // NOTE: state lives only in always_ff with <=; all next-state math is blocking in always_comb.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      gate_in_q  <= '0;
      err_q      <= '0;
      ff_vec_q   <= '0;
      ff_valid_q <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gate_in_q  <= gate_in_d;
      err_q      <= err_d;
      ff_vec_q   <= ff_vec_d;
      ff_valid_q <= ff_valid_d;
      pass_q     <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (sweep.start) state_d = ST_SETTLE;
      ST_SETTLE:        if (cnt_q == '0) state_d = ST_CHECK;
      ST_CHECK:         state_d = (last_vec || stop_hit) ? ST_DONE : ST_SETTLE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // NOTE: every signal gets its hold value first so no path through the case infers a latch.
  always_comb begin
    cnt_d      = cnt_q;
    gate_in_d  = gate_in_q;
    err_d      = err_q;
    ff_vec_d   = ff_vec_q;
    ff_valid_d = ff_valid_q;
    pass_d     = pass_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (sweep.start) begin
          gate_in_d  = '0;
          cnt_d      = CNT_LOAD;
          err_d      = '0;
          ff_vec_d   = '0;
          ff_valid_d = 1'b0;
          pass_d     = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      end
      ST_CHECK: begin
        if (mismatch) begin
          err_d = err_q + 1'b1;
          if (!ff_valid_q) begin
            ff_vec_d   = gate_in_q;
            ff_valid_d = 1'b1;
          end
        end
        // pass is judged on the count that already includes this vector.
        if (last_vec || stop_hit) begin
          pass_d = (err_d == '0);
        end else begin
          gate_in_d = gate_in_q + 1'b1;
          cnt_d     = CNT_LOAD;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    sweep.busy = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
    sweep.done = (state_q == ST_DONE);
  end

  assign sweep.gate_in          = gate_in_q;
  assign sweep.pass             = pass_q;
  assign sweep.err_count        = err_q;
  assign sweep.first_fail_vec   = ff_vec_q;
  assign sweep.first_fail_valid = ff_valid_q;

endmodule

// File: doc/gate_sweep_checker.md
Name: gate_sweep_checker

Overview:
- Synthesizable exhaustive truth-table sweeper for a combinational gate under test.
- Drives every input vector into the gate, waits a settle window, then samples the gate output and compares it against a built-in reference function.
- Reports mismatch count, the first failing vector, and an overall pass/fail flag.
- Sits directly around a gate instance: upstream as its stimulus source and downstream as its response checker, so gates can be verified on hardware or in plain RTL simulation.

Parameters:
- N_IN, 2: number of gate inputs; range 1..8.
- SETTLE, 2: cycles each vector is held before sampling; must be >= 1 (elaboration error otherwise).
- GATE_FN, 1: reference function; 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR; other values are an elaboration error.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  sweep request; sampled only in IDLE or DONE.
- gate_in  output  N_IN  registered stimulus to the gate under test; bit 0 = first gate input.
- gate_out  input  1  gate under test output.
- busy  output  1  high in SETTLE and CHECK.
- done  output  1  high in DONE; held until the next accepted start or reset.
- pass  output  1  valid when done=1; 1 iff err_count==0.
- err_count  output  N_IN+1  number of mismatching vectors; cannot overflow (max 2^N_IN).
- first_fail_vec  output  N_IN  first vector that mismatched.
- first_fail_valid  output  1  first_fail_vec holds a captured value.

Behaviour:
- Reset (async, any state): state=IDLE; gate_in=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, first_fail_valid=0, settle counter=0. Takes effect immediately, including mid-sweep; no partial result is kept.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE/DONE with start=1:
  - clear err_count, first_fail_*, done and pass;
  - gate_in<=0, settle counter<=SETTLE-1, go to SETTLE.
- IDLE/DONE with start=0: hold all outputs.
- SETTLE: counter decrements once per cycle; when it is 0, go to CHECK. Each vector therefore spends exactly SETTLE cycles in SETTLE.
- CHECK (1 cycle): sample gate_out; expected = GATE_FN reduced over all N_IN bits of gate_in.
  - On mismatch: err_count+1; if first_fail_valid=0, capture first_fail_vec<=gate_in and set first_fail_valid<=1.
  - If gate_in is all-ones: go to DONE with done<=1 and pass<=(final err_count==0). The final count includes this vector's result.
  - Otherwise: gate_in<=gate_in+1, counter<=SETTLE-1, go to SETTLE.
- Latency: done rises 2^N_IN*(SETTLE+1) clock edges after the edge that accepts start. For N_IN=2, SETTLE=2 this is 12 cycles.
- start while busy is ignored and has no side effects.
- gate_in changes only on the edge leaving CHECK or accepting start; it is stable for the whole settle window.
- Vector order is ascending binary, 0 to 2^N_IN-1, with no wrap past all-ones.
- gate_out X/Z is not detected in RTL; the bench is responsible for flagging unknowns.

Optional Feature:
- Macro: GATE_SWEEP_STOP_ON_FAIL_EN.
- Defined: the first mismatch in CHECK goes straight to DONE with err_count=1, pass=0, first_fail_* captured; gate_in holds the failing vector.
- Undefined: the full sweep always runs to the all-ones vector and counts every mismatch.

Test Plan:
- Correct OR gate (GATE_FN=1, N_IN=2, SETTLE=2); start pulse at cycle 0 -> gate_in steps 00,01,10,11, each held 3 cycles; done=1 at cycle 12; pass=1; err_count=0; first_fail_valid=0.
- gate_out tied 0 with GATE_FN=1 -> err_count=3, pass=0, first_fail_vec=01, first_fail_valid=1; with GATE_FN=4 (NOR) -> err_count=1, first_fail_vec=00.
- Start re-pulsed at cycle 5 mid-sweep -> ignored; sweep order and timing unchanged; done still at cycle 12. Start pulsed in DONE -> counters clear and a new sweep begins at gate_in=00.
- rst asserted at cycle 7 for 2 cycles -> all outputs return to reset values immediately; after release, start -> full 12-cycle sweep with fresh results.
- N_IN=3, GATE_FN=2 (XOR), correct gate, SETTLE=1 -> 8 vectors; done at cycle 16; pass=1.
- GATE_SWEEP_STOP_ON_FAIL_EN defined; OR DUT faulty only at vector 10 -> done at cycle 9; err_count=1; first_fail_vec=10; gate_in=10.
